// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider with start/busy/done handshake and divide-by-zero flag.
// Define SIGNED_DIV_EN to add the signed_mode port and the SIGN_FIX state.
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_ITER     = 5'b00010,
        S_CORRECT  = 5'b00100,
        S_SIGN_FIX = 5'b01000,
        S_DONE     = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ITER    = 4'b0010,
        S_CORRECT = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_a_iter;
    logic [WIDTH-1:0] w_rem_fix;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_dividend_neg;
    logic w_divisor_neg;

    assign w_dividend_neg = signed_mode & dividend[WIDTH-1];
    assign w_divisor_neg  = signed_mode & divisor[WIDTH-1];
    // -2^(WIDTH-1) maps onto itself, which still reads correctly as an unsigned magnitude.
    assign w_dividend_mag = w_dividend_neg ? -dividend : dividend;
    assign w_divisor_mag  = w_divisor_neg  ? -divisor  : divisor;
`else
    assign w_dividend_mag = dividend;
    assign w_divisor_mag  = divisor;
`endif

    // Shift and add/sub fused: the sign of the previous partial remainder picks the operation.
    assign w_a_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_a_iter  = r_a[WIDTH] ? (w_a_shift + {1'b0, r_m}) : (w_a_shift - {1'b0, r_m});
    assign w_rem_fix = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m) : r_a[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = (divisor == '0) ? S_DONE : S_ITER;
            S_ITER:    if (r_count == CW'(WIDTH - 1)) w_next = S_CORRECT;
`ifdef SIGNED_DIV_EN
            S_CORRECT:  w_next = S_SIGN_FIX;
            S_SIGN_FIX: w_next = S_DONE;
`else
            S_CORRECT: w_next = S_DONE;
`endif
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_a     <= '0;
                            r_q     <= w_dividend_mag;
                            r_m     <= w_divisor_mag;
                            r_count <= '0;
                            r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
                            r_neg_q <= w_dividend_neg ^ w_divisor_neg;
                            r_neg_r <= w_dividend_neg;
`endif
                        end
                    end
                end
                S_ITER: begin
                    r_a     <= w_a_iter;
                    r_q     <= {r_q[WIDTH-2:0], ~w_a_iter[WIDTH]};
                    r_count <= r_count + CW'(1);
                end
                S_CORRECT: begin
                    r_quotient  <= r_q;
                    r_remainder <= w_rem_fix;
                end
`ifdef SIGNED_DIV_EN
                S_SIGN_FIX: begin
                    if (r_neg_q) r_quotient  <= -r_quotient;
                    if (r_neg_r) r_remainder <= -r_remainder;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
